uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver: the far end of the existing 8N1 serial transmitter, for off-chip links where the serial input is asynchronous and noisy. Synchronises the line, samples each bit at OVERSAMPLE× baud with 3-sample majority vote, rejects false starts, flags framing errors, and presents bytes through a valid/ready holding register with overrun detection. Sits between the board RX pin and any byte consumer.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, Hz.
- BAUD, 115200: line rate, bit/s.
- OVERSAMPLE, 16: samples per bit; fixed at 16 (vote indices below assume it).
- Derived DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division; must be ≥1 (27 at defaults).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  8  received byte, LSB first on the line.
- data_valid  out  1  data_out holds an unconsumed byte.
- data_ready  in  1  consumer accepts byte when data_valid & data_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped, holding register full.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input: two-flop synchroniser on rx, both flops reset to 1; FSM uses the second flop (rx_s).
- Tick generator: counter 0..DIV-1, tick on DIV-1; cleared when IDLE detects rx_s low, so ticks align to the start edge.
- Sample counter s (0..15) advances on each tick; bit counter b (0..7).
- Majority vote of rx_s at s = 7, 8, 9; result valid on the tick for s=9.
- States:
  - IDLE: rx_s=0 -> START, s=0, tick counter cleared.
  - START: vote at s=9; vote=1 -> IDLE (false start, no flags). Else at s=15 -> DATA, b=0.
  - DATA: vote at s=9 shifted into shift register MSB (right shift, LSB-first). At s=15: b=7 -> STOP, else b++.
  - STOP: at s=9 vote=1 -> load byte, IDLE; vote=0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s=1, then IDLE (prevents break condition retriggering).
- Return to IDLE mid-stop-bit (s=9) is deliberate: tolerates transmitter clock up to ~3% fast.
- Holding register at stop-bit completion with good stop:
  - data_valid=0: load data_out, data_valid=1.
  - data_valid=1 and data_ready=1 same cycle: load new byte, data_valid stays 1, no overrun.
  - data_valid=1, data_ready=0: overrun pulse, new byte dropped, data_out unchanged.
- data_valid & data_ready with no new byte: data_valid=0 next cycle; data_out keeps last value.
- frame_err and overrun never assert together for one frame.

## Timing
- Reset values: data_out=0x00, data_valid=0, frame_err=0, overrun=0, busy=0; FSM IDLE; counters 0; synchroniser 1.
- Reset mid-frame: partial byte discarded; after release, waits for a fresh falling edge.
- rx to rx_s: 2 clk latency.
- Start edge on rx to data_valid rise: 2 + (9*16 + 9 + 1)*DIV clk ±1 (≈9.6 bit times).
- data_valid, frame_err, overrun, data_out registered; all change on the clk edge after the s=9 stop tick.
- busy rises the cycle after IDLE sees rx_s=0; falls entering IDLE.
- Glitch rejection: any low pulse shorter than ~7 ticks at start is a false start.
- Back-to-back frames (no idle between stop and next start) received without loss.

## Test plan
Bench: CLK_FREQ=3_200_000, BAUD=100_000 (DIV=2, 32 clk/bit), 8N1 bench driver.
- Send 0xA5, data_ready=1 -> data_valid one-cycle pulse, data_out=0xA5, frame_err=0, overrun=0, busy back to 0.
- rx low for 6 clk then high -> busy pulses, no data_valid, no frame_err; next byte 0x3C received correctly.
- Send 0x3C with stop bit 0, hold rx low 3 bit times, release, send 0x81 -> one frame_err pulse, no data_valid for 0x3C, then data_out=0x81 valid.
- data_ready=0, send 0x11 then 0x22 -> data_valid=1 with 0x11, one overrun pulse at second stop, data_out stays 0x11; pulse data_ready -> data_valid=0 next cycle.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap, data_ready=1 -> three data_valid pulses in order, no flags.
- Assert rst mid-DATA of 0x96 -> all outputs reset immediately; after release send 0x5A -> data_out=0x5A, no spurious flags.

Source files
------------

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//
// Oversampling 8N1 UART receiver. The asynchronous serial input is brought
// into the clk domain through a two-flop synchroniser. Each bit is then
// sampled at OVERSAMPLE x baud, and a 3-sample majority vote is taken near
// mid-bit. The receiver rejects false starts and flags framing errors.
// Received bytes go to the consumer through a valid/ready holding register
// that reports overruns.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s
//   OVERSAMPLE  samples per bit; the vote positions assume 16
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   data_out    last received byte (LSB first on the line)
//   data_valid  data_out holds a byte the consumer has not taken yet
//   data_ready  consumer takes the byte when data_valid & data_ready
//   frame_err   one-cycle pulse: stop bit was voted low
//   overrun     one-cycle pulse: good byte dropped because register was full
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Clock cycles per oversample tick. The value must be at least 1.
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state;

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       s_cnt;
  logic [2:0]       b_cnt;
  logic             samp7;
  logic             samp8;
  logic             vote;
  logic [7:0]       shift_reg;

  // Two-flop synchroniser for the asynchronous line. Both flops reset to the
  // idle level so that reset release is not mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // One tick per oversample period. The tick counter is held at zero while
  // idle, so the first tick of a frame falls DIV cycles after the start edge.
  always_comb begin
    tick = (div_cnt == DIV_LAST);
  end

  // Majority of the samples taken at s=7, s=8 and the live sample at s=9.
  // The result is meaningful only on the tick where s_cnt == 9.
  always_comb begin
    vote = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  end

  // Receiver FSM. It also holds the counters, the shift register and all
  // registered outputs, so every output changes on a single clock edge.
  // The frame is given up at the s=9 tick of the stop bit, not at the end
  // of that bit. This leaves slack for a transmitter whose clock runs a few
  // percent fast, and lets back-to-back frames be received without loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      s_cnt      <= '0;
      b_cnt      <= '0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state != IDLE && tick) begin
        s_cnt <= s_cnt + 4'd1;
        if (s_cnt == 4'd7) begin
          samp7 <= rx_s;
        end
        if (s_cnt == 4'd8) begin
          samp8 <= rx_s;
        end
      end

      case (state)
        IDLE: begin
          s_cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (s_cnt == 4'd9 && vote) begin
              // The line went back high before mid-bit, so this was a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end else if (s_cnt == 4'd15) begin
              state <= DATA;
              b_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd9) begin
              shift_reg <= {vote, shift_reg[7:1]};
            end
            if (s_cnt == 4'd15) begin
              if (b_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                b_cnt <= b_cnt + 3'd1;
              end
            end
          end
        end

        STOP: begin
          if (tick && s_cnt == 4'd9) begin
            if (vote) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A byte taken by the consumer in this same cycle frees the
              // register, so the new byte can replace it without an overrun.
              if (!data_valid || data_ready) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          // A line held low (a break) must not start a new frame. Wait here
          // until the line returns high.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
//
// Self-checking bench for uart_rx_os, with DIV = 2 (32 clk per bit).
// The stimulus side drives 8N1 frames on rx. For each frame it pushes the
// expected receiver event (byte, framing error or overrun) into a queue.
// A monitor samples on the falling clock edge. It pops and compares one
// entry for every event the DUT presents.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLK  = 32;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic prev_valid;
  logic prev_ready;

  uart_rx_os #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // 100 MHz nominal bench clock; only the cycle count per bit matters.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreEvent(input int kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d data 0x%0h expected none",
               kind, data);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      if (kind == EV_BYTE) begin
        checkOutput("byte_data", {24'd0, data}, {24'd0, e.data});
      end
    end
  endtask

  task automatic expectEvent(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drives one 8N1 frame, starting and ending on a falling clock edge.
  task automatic applyStimulus(input logic [7:0] byte_val, input logic stop_val);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = byte_val[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Monitor: pops one expectation for every presented event. It also checks
  // that an accepted byte clears data_valid on the following cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (frame_err) scoreEvent(EV_FERR, 8'h00);
      if (overrun) scoreEvent(EV_OVR, 8'h00);
      if (data_valid && !prev_valid) scoreEvent(EV_BYTE, data_out);
      if (prev_valid && prev_ready) checkOutput("valid_clear", {31'd0, data_valid}, 32'd0);
      prev_valid = data_valid;
      prev_ready = data_ready;
    end
  end

  initial begin
    logic saw_busy;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'h00);
    checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Single byte, consumer always ready.
    $display("[TB] single byte 0xA5");
    data_ready = 1'b1;
    expectEvent(EV_BYTE, 8'hA5);
    applyStimulus(8'hA5, 1'b1);
    checkOutput("a5_busy_idle", {31'd0, busy}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Short low glitch: a false start with no output.
    $display("[TB] glitch rejection");
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    checkOutput("glitch_busy_pulse", {31'd0, saw_busy}, 32'd1);
    checkOutput("glitch_busy_idle", {31'd0, busy}, 32'd0);
    expectEvent(EV_BYTE, 8'h3C);
    applyStimulus(8'h3C, 1'b1);
    repeat (BIT_CLK) @(negedge clk);

    // Framing error followed by a break, then a good frame.
    $display("[TB] framing error and break");
    expectEvent(EV_FERR, 8'h00);
    applyStimulus(8'h3C, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    checkOutput("ferr_busy_in_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    checkOutput("ferr_busy_idle", {31'd0, busy}, 32'd0);
    expectEvent(EV_BYTE, 8'h81);
    applyStimulus(8'h81, 1'b1);
    checkOutput("ferr_then_81", {24'd0, data_out}, 32'h81);
    repeat (BIT_CLK) @(negedge clk);

    // Overrun: the consumer stalls across two frames.
    $display("[TB] overrun");
    data_ready = 1'b0;
    expectEvent(EV_BYTE, 8'h11);
    applyStimulus(8'h11, 1'b1);
    expectEvent(EV_OVR, 8'h00);
    applyStimulus(8'h22, 1'b1);
    checkOutput("ovr_data_kept", {24'd0, data_out}, 32'h11);
    checkOutput("ovr_valid_held", {31'd0, data_valid}, 32'd1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput("ovr_valid_cleared", {31'd0, data_valid}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Back-to-back frames with no idle gap.
    $display("[TB] back-to-back frames");
    data_ready = 1'b1;
    expectEvent(EV_BYTE, 8'h00);
    expectEvent(EV_BYTE, 8'hFF);
    expectEvent(EV_BYTE, 8'h55);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("b2b_last_data", {24'd0, data_out}, 32'h55);
    repeat (BIT_CLK) @(negedge clk);

    // Reset in the middle of the data bits of 0x96.
    $display("[TB] reset mid-frame");
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_data_out", {24'd0, data_out}, 32'h00);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("midreset_flags", {30'd0, frame_err, overrun}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    expectEvent(EV_BYTE, 8'h5A);
    applyStimulus(8'h5A, 1'b1);
    checkOutput("post_reset_data", {24'd0, data_out}, 32'h5A);
    repeat (BIT_CLK) @(negedge clk);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
